// File: rtl/dmem_pkg.sv
// Shared types, funct3 encodings and lane helpers for the data-side bus controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Unknown funct3 codes fall through to word size.
    function automatic logic [1:0] access_size(input logic       wr,
                                               input logic [2:0] st,
                                               input logic [2:0] lt);
        logic [1:0] sz;
        if (wr) begin
            case (st)
                F3_SB:   sz = SZ_BYTE;
                F3_SH:   sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (lt)
                F3_LB, F3_LBU: sz = SZ_BYTE;
                F3_LH, F3_LHU: sz = SZ_HALF;
                default:       sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] addr);
        return (sz == SZ_HALF) ? addr[0] : (sz == SZ_WORD) ? (addr != 2'b00) : 1'b0;
    endfunction

    function automatic logic [1:0] align_lo(input logic [1:0] sz, input logic [1:0] addr);
        return (sz == SZ_HALF) ? {addr[1], 1'b0} : (sz == SZ_WORD) ? 2'b00 : addr;
    endfunction

    function automatic logic [3:0] be_gen(input logic [2:0] store_type, input logic [1:0] addr);
        logic [3:0] be;
        case (store_type)
            F3_SB:   be = 4'b0001 << addr;
            F3_SH:   be = addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] wdata_gen(input logic [2:0] store_type, input logic [31:0] data);
        logic [31:0] w;
        case (store_type)
            F3_SB:   w = {4{data[7:0]}};
            F3_SH:   w = {2{data[15:0]}};
            default: w = data;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/load_extender.sv
// Selects the addressed byte/half from a memory word and sign- or zero-extends it.
module load_extender
    import dmem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  load_type,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        case (load_type)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  result = {24'b0, byte_sel};
            F3_LHU:  result = {16'b0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// RV32I data-port to word-RAM controller with byte enables, load extension and bus timeout.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses skip memory and raise bus_err.
//
// state | meaning
// IDLE  | waiting for d_wr_en/d_rd_en; stall follows the request combinationally
// BUSY  | mem_req held until mem_ready or timeout
// DONE  | one cycle with stall low so the core retires the access
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int MEM_AW  = 10,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_wr_en,
    input  logic              d_rd_en,
    input  logic [31:0]       dAddr,
    input  logic [31:0]       dWdata,
    input  logic [2:0]        store_type,
    input  logic [2:0]        load_type,
    output logic [31:0]       dRdata,
    output logic              stall,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  count;
    logic [2:0]  lt_q;
    logic [1:0]  lane_q;
    logic        req;
    logic [1:0]  sz;
    logic [1:0]  addr_lo;
    logic        trap;
    logic [31:0] ext;
    logic        unused_addr_bits;

    assign req              = d_wr_en | d_rd_en;
    assign sz               = access_size(d_wr_en, store_type, load_type);
    assign addr_lo          = align_lo(sz, dAddr[1:0]);
    assign unused_addr_bits = ^{dAddr[31:MEM_AW+2]};

`ifdef MISALIGN_TRAP_EN
    assign trap = is_misaligned(sz, dAddr[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign stall   = (state == IDLE) ? req : (state == BUSY);
    assign mem_req = (state == BUSY);

    load_extender u_load_extender (
        .rdata     (mem_rdata),
        .addr      (lane_q),
        .load_type (lt_q),
        .result    (ext)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            lt_q      <= '0;
            lane_q    <= '0;
            bus_err   <= 1'b0;
            dRdata    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (trap) begin
                            state   <= DONE;
                            bus_err <= 1'b1;
                            dRdata  <= '0;
                        end else begin
                            state    <= BUSY;
                            count    <= '0;
                            mem_we   <= d_wr_en;
                            mem_addr <= dAddr[MEM_AW+1:2];
                            mem_be   <= d_wr_en ? be_gen(store_type, addr_lo) : 4'b1111;
                            lt_q     <= load_type;
                            lane_q   <= addr_lo;
                            if (d_wr_en) mem_wdata <= wdata_gen(store_type, dWdata);
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        if (!mem_we) dRdata <= ext;
                        state <= DONE;
                    end else if (count == TO_LAST) begin
                        bus_err <= 1'b1;
                        dRdata  <= '0;
                        state   <= DONE;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: byte-level reference memory, word RAM responder, directed and random accesses.
module tb_dmem_access_ctrl;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        d_wr_en, d_rd_en;
    logic [31:0] dAddr, dWdata;
    logic [2:0]  store_type, load_type;
    logic [31:0] dRdata;
    logic        stall, bus_err, mem_req, mem_we;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ready;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ram [0:1023];
    logic [7:0]  ref_bytes [0:4095];

    logic        r_saw_req, r_we, r_err, r_err_after, r_timeout;
    logic [9:0]  r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata, r_rdata;
    int          r_busy, r_stall_cycles;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.MEM_AW(10), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .d_wr_en(d_wr_en), .d_rd_en(d_rd_en),
        .dAddr(dAddr), .dWdata(dWdata), .store_type(store_type), .load_type(load_type),
        .dRdata(dRdata), .stall(stall), .bus_err(bus_err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    function automatic int ld_size(input logic [2:0] lt);
        case (lt)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic int st_size(input logic [2:0] st);
        case (st)
            3'b000:  return 1;
            3'b001:  return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit ref_mis(input int sz, input logic [31:0] a);
        return (int'(a[1:0]) % sz) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] lt, input logic [31:0] a);
        int          sz;
        logic [31:0] base;
        logic [31:0] v;
        sz   = ld_size(lt);
        base = a & ~32'(sz - 1);
        v    = 32'h0;
        for (int i = 0; i < sz; i++) v = v | (32'(ref_bytes[int'(base[11:0]) + i]) << (8 * i));
        if (sz < 4 && !lt[2] && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] st, input logic [31:0] a, input logic [31:0] d);
        int          sz;
        logic [31:0] base;
        sz   = st_size(st);
        base = a & ~32'(sz - 1);
        for (int i = 0; i < sz; i++) ref_bytes[int'(base[11:0]) + i] = d[8*i +: 8];
    endtask

    // One core access from an IDLE negedge back to the negedge after DONE; delay<0 = RAM never answers.
    task automatic access(input bit wr, input bit rd, input logic [2:0] st, input logic [2:0] lt,
                          input logic [31:0] a, input logic [31:0] wd, input int delay, input bit spurious);
        int n;
        bit done;
        r_saw_req = 0; r_busy = 0; r_stall_cycles = 0; r_timeout = 0;
        r_we = 0; r_addr = '0; r_be = '0; r_wdata = '0;
        d_wr_en = wr; d_rd_en = rd; store_type = st; load_type = lt;
        dAddr = a; dWdata = wd; mem_ready = spurious; mem_rdata = $urandom;
        #1;
        if (stall) r_stall_cycles++;
        @(posedge clk); @(negedge clk);
        d_wr_en = 0; d_rd_en = 0; dAddr = $urandom; dWdata = $urandom;
        store_type = 3'($urandom); load_type = 3'($urandom); mem_ready = 0;
        n = 0; done = 0;
        while (!done) begin
            if (!stall) done = 1;
            else if (n >= 300) begin r_timeout = 1; done = 1; end
            else begin
                r_stall_cycles++;
                if (mem_req) begin
                    if (!r_saw_req) begin
                        r_we = mem_we; r_addr = mem_addr; r_be = mem_be; r_wdata = mem_wdata;
                    end
                    r_saw_req = 1;
                    if (delay >= 0 && r_busy == delay) begin
                        mem_ready = 1;
                        mem_rdata = ram[mem_addr];
                        if (mem_we)
                            for (int i = 0; i < 4; i++)
                                if (mem_be[i]) ram[mem_addr][8*i +: 8] = mem_wdata[8*i +: 8];
                    end else begin
                        mem_rdata = $urandom;
                    end
                    r_busy++;
                end
                @(posedge clk); @(negedge clk);
                mem_ready = 0; n++;
            end
        end
        r_rdata = dRdata;
        r_err   = bus_err;
        @(posedge clk); @(negedge clk);
        r_err_after = bus_err;
    endtask

    task automatic test_reset;
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL reset_bus_err got=%b exp=0", bus_err); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", stall); end
        n_cmp++; if ({mem_be, mem_addr} !== 14'h0) begin n_err++; $display("FAIL reset_be_addr got=%h/%h exp=0/0", mem_be, mem_addr); end
        n_cmp++; if ({mem_wdata, dRdata} !== 64'h0) begin n_err++; $display("FAIL reset_wdata_rdata got=%h/%h exp=0/0", mem_wdata, dRdata); end
    endtask

    task automatic test_store_lanes;
        access(1, 0, 3'b010, 3'b000, 32'h10, 32'hDEAD_BEEF, 0, 0);
        ref_store(3'b010, 32'h10, 32'hDEAD_BEEF);
        n_cmp++; if (r_we !== 1'b1) begin n_err++; $display("FAIL sw_we got=%b exp=1", r_we); end
        n_cmp++; if (r_addr !== 10'd4) begin n_err++; $display("FAIL sw_addr got=%0d exp=4", r_addr); end
        n_cmp++; if (r_be !== 4'b1111) begin n_err++; $display("FAIL sw_be got=%b exp=1111", r_be); end
        n_cmp++; if (r_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL sw_wdata got=%h exp=deadbeef", r_wdata); end
        n_cmp++; if (r_stall_cycles != 2) begin n_err++; $display("FAIL sw_stall_cycles got=%0d exp=2", r_stall_cycles); end
        access(1, 0, 3'b000, 3'b000, 32'h13, 32'h0000_00A5, 1, 0);
        ref_store(3'b000, 32'h13, 32'h0000_00A5);
        n_cmp++; if (r_be !== 4'b1000) begin n_err++; $display("FAIL sb_be got=%b exp=1000", r_be); end
        n_cmp++; if (r_wdata !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", r_wdata); end
        access(1, 0, 3'b001, 3'b000, 32'h16, 32'h1234_ABCD, 2, 1);
        ref_store(3'b001, 32'h16, 32'h1234_ABCD);
        n_cmp++; if (r_be !== 4'b1100) begin n_err++; $display("FAIL sh_be got=%b exp=1100", r_be); end
        n_cmp++; if (r_wdata !== 32'hABCD_ABCD) begin n_err++; $display("FAIL sh_wdata got=%h exp=abcdabcd", r_wdata); end
    endtask

    task automatic test_load_ext;
        access(0, 1, 3'b000, 3'b100, 32'h13, 32'h0, 0, 0);
        n_cmp++; if (r_rdata !== 32'h0000_00A5) begin n_err++; $display("FAIL lbu got=%h exp=000000a5", r_rdata); end
        n_cmp++; if (r_be !== 4'b1111) begin n_err++; $display("FAIL read_be got=%b exp=1111", r_be); end
        access(0, 1, 3'b000, 3'b000, 32'h13, 32'h0, 1, 0);
        n_cmp++; if (r_rdata !== 32'hFFFF_FFA5) begin n_err++; $display("FAIL lb got=%h exp=ffffffa5", r_rdata); end
        access(1, 0, 3'b010, 3'b000, 32'h10, 32'h8001_1234, 0, 0);
        ref_store(3'b010, 32'h10, 32'h8001_1234);
        access(0, 1, 3'b000, 3'b001, 32'h12, 32'h0, 3, 0);
        n_cmp++; if (r_rdata !== 32'hFFFF_8001) begin n_err++; $display("FAIL lh got=%h exp=ffff8001", r_rdata); end
        access(0, 1, 3'b000, 3'b101, 32'h12, 32'h0, 0, 1);
        n_cmp++; if (r_rdata !== 32'h0000_8001) begin n_err++; $display("FAIL lhu got=%h exp=00008001", r_rdata); end
    endtask

    task automatic test_timeout;
        access(0, 1, 3'b000, 3'b010, 32'h10, 32'h0, 0, 0);
        n_cmp++; if (r_rdata !== 32'h8001_1234) begin n_err++; $display("FAIL pre_timeout_lw got=%h exp=80011234", r_rdata); end
        access(0, 1, 3'b000, 3'b010, 32'h40, 32'h0, -1, 0);
        n_cmp++; if (r_busy != 4) begin n_err++; $display("FAIL timeout_busy_cycles got=%0d exp=4", r_busy); end
        n_cmp++; if (r_err !== 1'b1) begin n_err++; $display("FAIL timeout_bus_err got=%b exp=1", r_err); end
        n_cmp++; if (r_err_after !== 1'b0) begin n_err++; $display("FAIL timeout_err_pulse got=%b exp=0", r_err_after); end
        n_cmp++; if (r_rdata !== 32'h0) begin n_err++; $display("FAIL timeout_rdata got=%h exp=0", r_rdata); end
        n_cmp++; if (r_stall_cycles != 5) begin n_err++; $display("FAIL timeout_stall_cycles got=%0d exp=5", r_stall_cycles); end
    endtask

    task automatic test_misalign;
        logic [31:0] exp;
        access(1, 0, 3'b010, 3'b000, 32'h0, 32'h7654_3210, 0, 0);
        ref_store(3'b010, 32'h0, 32'h7654_3210);
        access(0, 1, 3'b000, 3'b010, 32'h02, 32'h0, 0, 0);
        exp = TRAP ? 32'h0 : ref_load(3'b010, 32'h0);
        n_cmp++; if (r_saw_req !== !TRAP) begin n_err++; $display("FAIL misalign_req got=%b exp=%b", r_saw_req, !TRAP); end
        n_cmp++; if (r_err !== TRAP) begin n_err++; $display("FAIL misalign_err got=%b exp=%b", r_err, TRAP); end
        n_cmp++; if (r_rdata !== exp) begin n_err++; $display("FAIL misalign_rdata got=%h exp=%h", r_rdata, exp); end
        if (r_saw_req) begin
            n_cmp++; if (r_addr !== 10'd0) begin n_err++; $display("FAIL misalign_addr got=%0d exp=0", r_addr); end
        end
        access(1, 0, 3'b001, 3'b000, 32'h05, 32'h0000_BBAA, 0, 0);
        if (!TRAP) ref_store(3'b001, 32'h05, 32'h0000_BBAA);
        access(0, 1, 3'b000, 3'b010, 32'h04, 32'h0, 0, 0);
        exp = ref_load(3'b010, 32'h04);
        n_cmp++; if (r_rdata !== exp) begin n_err++; $display("FAIL misalign_sh_mem got=%h exp=%h", r_rdata, exp); end
    endtask

    task automatic test_reset_mid;
        d_rd_en = 1; load_type = 3'b010; dAddr = 32'h20;
        @(posedge clk); @(negedge clk);
        d_rd_en = 0;
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL mid_busy_req got=%b exp=1", mem_req); end
        reset = 0;
        #1;
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL mid_reset_req got=%b exp=0", mem_req); end
        @(posedge clk); @(negedge clk);
        reset = 1;
        @(posedge clk); @(negedge clk);
        access(1, 0, 3'b010, 3'b000, 32'h24, 32'hCAFE_F00D, 1, 0);
        ref_store(3'b010, 32'h24, 32'hCAFE_F00D);
        access(0, 1, 3'b000, 3'b010, 32'h24, 32'h0, 0, 0);
        n_cmp++; if (r_rdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL post_reset_lw got=%h exp=cafef00d", r_rdata); end
    endtask

    task automatic test_back_to_back;
        access(1, 1, 3'b010, 3'b010, 32'h28, 32'h1357_9BDF, 0, 0);
        ref_store(3'b010, 32'h28, 32'h1357_9BDF);
        n_cmp++; if (r_we !== 1'b1) begin n_err++; $display("FAIL both_en_we got=%b exp=1", r_we); end
        access(0, 1, 3'b000, 3'b010, 32'h28, 32'h0, 0, 0);
        n_cmp++; if (r_rdata !== 32'h1357_9BDF) begin n_err++; $display("FAIL b2b_lw got=%h exp=13579bdf", r_rdata); end
    endtask

    task automatic test_random;
        bit          wr, rd, mis, trapped;
        logic [2:0]  st, lt;
        logic [31:0] a, wd, exp;
        for (int k = 0; k < 80; k++) begin
            wr = 1'($urandom);
            rd = !wr || 1'($urandom);
            st = 3'($urandom); lt = 3'($urandom);
            a  = $urandom_range(0, 255);
            wd = $urandom;
            mis = wr ? ref_mis(st_size(st), a) : ref_mis(ld_size(lt), a);
            trapped = TRAP && mis;
            access(wr, rd, st, lt, a, wd, $urandom_range(0, 3), 1'($urandom));
            n_cmp++; if (r_err !== trapped) begin n_err++; $display("FAIL rnd_err[%0d] got=%b exp=%b", k, r_err, trapped); end
            n_cmp++; if (r_saw_req !== !trapped) begin n_err++; $display("FAIL rnd_req[%0d] got=%b exp=%b", k, r_saw_req, !trapped); end
            if (r_saw_req) begin
                n_cmp++; if ({r_we, r_addr} !== {wr, a[11:2]}) begin n_err++; $display("FAIL rnd_we_addr[%0d] got=%b/%0d exp=%b/%0d", k, r_we, r_addr, wr, a[11:2]); end
            end
            if (wr) begin
                if (!trapped) ref_store(st, a, wd);
            end else begin
                exp = trapped ? 32'h0 : ref_load(lt, a);
                n_cmp++; if (r_rdata !== exp) begin n_err++; $display("FAIL rnd_rdata[%0d] lt=%b a=%h got=%h exp=%h", k, lt, a, r_rdata, exp); end
            end
            n_cmp++; if (r_timeout !== 1'b0) begin n_err++; $display("FAIL rnd_hang[%0d] got=1 exp=0", k); end
        end
    endtask

    initial begin
        logic [31:0] w;
        reset = 0; d_wr_en = 0; d_rd_en = 0; dAddr = '0; dWdata = '0;
        store_type = '0; load_type = '0; mem_rdata = '0; mem_ready = 0;
        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            ram[i] = w;
            for (int j = 0; j < 4; j++) ref_bytes[4*i + j] = w[8*j +: 8];
        end
        repeat (3) @(negedge clk);
        test_reset;
        reset = 1;
        @(negedge clk);
        test_store_lanes;
        test_load_ext;
        test_timeout;
        test_misalign;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
